// File: rtl/gprs_mp_pkg.sv
// Shared constants and types for the gprs_mp register file.
// Holds the debug regno base, the default data width and the debug FSM state type.
package gprs_mp_pkg;

  localparam logic [15:0] GPRS_DBG_BASE   = 16'h1000;
  localparam int unsigned GPRS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } dbg_state_e;

endpackage

// File: rtl/gprs_mp_dbg_fsm.sv
// Debug access handshake for gprs_mp: regno decode, wait-for-idle-write-port,
// starvation counter driving wr_stall, and registered ack/err outputs.
module gprs_dbg_fsm
  import gprs_mp_pkg::*;
#(
  parameter  int unsigned NREGS        = 32,
  parameter  int unsigned DBG_WAIT_MAX = 15,
  localparam int unsigned AW           = $clog2(NREGS),
  localparam int unsigned CW           = $clog2(DBG_WAIT_MAX + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          dbg_req,
  input  logic          dbg_wr1_rd0,
  input  logic [15:0]   dbg_regno,
  input  logic          wr_any,
  output logic          dbg_we,
  output logic [AW-1:0] dbg_idx,
  output logic          dbg_cap,
  output logic          dbg_ack,
  output logic          dbg_err,
  output logic          wr_stall
);

  dbg_state_e    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic [16:0]   off;
  logic          in_range;

  // Regnos below the base wrap to a large 17-bit offset and fail the range test.
  assign off      = {1'b0, dbg_regno} - {1'b0, GPRS_DBG_BASE};
  assign in_range = off < 17'(NREGS);
  assign dbg_idx  = off[AW-1:0];

  // Combinational so that an asynchronous reset drops the stall immediately.
  assign wr_stall = (state == ST_WAIT) && (cnt >= CW'(DBG_WAIT_MAX));

  always_comb begin
    state_nxt = state;
    dbg_we    = 1'b0;
    dbg_cap   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dbg_req) begin
          if (!in_range) begin
            state_nxt = ST_ACK;
          end else if (!dbg_wr1_rd0) begin
            dbg_cap   = 1'b1;
            state_nxt = ST_ACK;
          end else if (!wr_any) begin
            dbg_we    = 1'b1;
            state_nxt = ST_ACK;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!wr_any) begin
          dbg_we    = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK:  state_nxt = ST_HOLD;
      ST_HOLD: if (!dbg_req) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      err_q   <= 1'b0;
      dbg_ack <= 1'b0;
      dbg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      dbg_ack <= (state == ST_ACK);
      dbg_err <= (state == ST_ACK) && err_q;
      if (state == ST_IDLE && dbg_req) err_q <= !in_range;
      if (state == ST_WAIT && state_nxt == ST_WAIT) begin
        if (cnt < CW'(DBG_WAIT_MAX)) cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/gprs_mp.sv
// Multi-port GPR file: NUM_RD async reads, NUM_WR sync writes, x0 hard-wired to zero, debug port.
// Optional same-cycle write-to-read forwarding when KRV_GPRS_BYPASS_EN is defined.
module gprs_mp
  import gprs_mp_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = GPRS_DATA_WIDTH,
  parameter  int unsigned NREGS        = 32,
  parameter  int unsigned NUM_RD       = 2,
  parameter  int unsigned NUM_WR       = 2,
  parameter  int unsigned DBG_WAIT_MAX = 15,
  localparam int unsigned AW           = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_RD*AW-1:0]         rd_idx,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic [NUM_WR-1:0]            wr_valid,
  input  logic [NUM_WR*AW-1:0]         wr_idx,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  output logic                         wr_stall,
  input  logic                         dbg_req,
  input  logic                         dbg_wr1_rd0,
  input  logic [15:0]                  dbg_regno,
  input  logic [DATA_WIDTH-1:0]        dbg_wdata,
  output logic                         dbg_ack,
  output logic                         dbg_err,
  output logic [DATA_WIDTH-1:0]        dbg_rdata
);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  dbg_we;
  logic                  dbg_cap;
  logic [AW-1:0]         dbg_idx;

  gprs_dbg_fsm #(
    .NREGS        (NREGS),
    .DBG_WAIT_MAX (DBG_WAIT_MAX)
  ) u_dbg_fsm (
    .clk         (clk),
    .rstn        (rstn),
    .dbg_req     (dbg_req),
    .dbg_wr1_rd0 (dbg_wr1_rd0),
    .dbg_regno   (dbg_regno),
    .wr_any      (|wr_valid),
    .dbg_we      (dbg_we),
    .dbg_idx     (dbg_idx),
    .dbg_cap     (dbg_cap),
    .dbg_ack     (dbg_ack),
    .dbg_err     (dbg_err),
    .wr_stall    (wr_stall)
  );

  // Debug write first, then core ports in ascending order: later assignments win.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (dbg_we && dbg_idx != '0) regs[dbg_idx] <= dbg_wdata;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_valid[w] && wr_idx[w*AW +: AW] != '0)
          regs[wr_idx[w*AW +: AW]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_idx[p*AW +: AW] != '0)
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_idx[p*AW +: AW]];
`ifdef KRV_GPRS_BYPASS_EN
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_valid[w] && rd_idx[p*AW +: AW] != '0 &&
            wr_idx[w*AW +: AW] == rd_idx[p*AW +: AW])
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dbg_rdata <= '0;
    end else if (dbg_cap) begin
      dbg_rdata <= (dbg_idx == '0) ? '0 : regs[dbg_idx];
    end
  end

endmodule

// File: tb/tb_gprs_mp.sv
// Directed self-checking bench for gprs_mp (2 read ports, 2 write ports, 32 x 32-bit).
module tb_gprs_mp;

  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  wr_valid;
  logic [9:0]  wr_idx;
  logic [63:0] wr_data;
  logic        wr_stall;
  logic        dbg_req;
  logic        dbg_wr1_rd0;
  logic [15:0] dbg_regno;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic        dbg_err;
  logic [31:0] dbg_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gprs_mp #(
    .DATA_WIDTH   (32),
    .NREGS        (32),
    .NUM_RD       (2),
    .NUM_WR       (2),
    .DBG_WAIT_MAX (15)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .wr_valid    (wr_valid),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .wr_stall    (wr_stall),
    .dbg_req     (dbg_req),
    .dbg_wr1_rd0 (dbg_wr1_rd0),
    .dbg_regno   (dbg_regno),
    .dbg_wdata   (dbg_wdata),
    .dbg_ack     (dbg_ack),
    .dbg_err     (dbg_err),
    .dbg_rdata   (dbg_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise a debug request at a negedge and count negedges until dbg_ack is seen (bounded).
  task automatic dbg_op(input logic w, input logic [15:0] r, input logic [31:0] d,
                        output int cyc);
    @(negedge clk);
    dbg_req = 1'b1; dbg_wr1_rd0 = w; dbg_regno = r; dbg_wdata = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dbg_ack && cyc < 60);
  endtask

  int cyc;
  int acks;

  initial begin
    rstn = 1'b0; rd_idx = '0; wr_valid = '0; wr_idx = '0; wr_data = '0;
    dbg_req = 1'b0; dbg_wr1_rd0 = 1'b0; dbg_regno = '0; dbg_wdata = '0;
    #12;
    for (int i = 0; i < 32; i++) begin
      rd_idx = {5'(i), 5'(31 - i)};
      #1;
      chk("rst_rd0", rd_data[31:0], 32'h0);
      chk("rst_rd1", rd_data[63:32], 32'h0);
    end
    chk("rst_stall", {31'h0, wr_stall}, 32'h0);
    chk("rst_ack", {31'h0, dbg_ack}, 32'h0);
    chk("rst_err", {31'h0, dbg_err}, 32'h0);
    chk("rst_rdata", dbg_rdata, 32'h0);
    @(negedge clk) rstn = 1'b1;

    // Same-index dual write: port 1 wins
    @(negedge clk);
    wr_valid = 2'b11; wr_idx = {5'd5, 5'd5}; wr_data = {32'hBBBB_0002, 32'hAAAA_0001};
    @(negedge clk);
    wr_valid = 2'b00; rd_idx = {5'd5, 5'd5};
    #1;
    chk("prio_rd0", rd_data[31:0], 32'hBBBB_0002);
    chk("prio_rd1", rd_data[63:32], 32'hBBBB_0002);

    // x0 write discarded, port 1 writes idx 6
    @(negedge clk);
    wr_valid = 2'b11; wr_idx = {5'd6, 5'd0}; wr_data = {32'h0000_0066, 32'hFFFF_FFFF};
    @(negedge clk);
    wr_valid = 2'b00; rd_idx = {5'd6, 5'd0};
    #1;
    chk("x0_rd", rd_data[31:0], 32'h0);
    chk("idx6_rd", rd_data[63:32], 32'h0000_0066);

    // Write idx 3 while reading it
    @(negedge clk);
    wr_valid = 2'b01; wr_idx = {5'd0, 5'd3}; wr_data = {32'h0, 32'h0000_1234};
    rd_idx = {5'd6, 5'd3};
    #1;
`ifdef KRV_GPRS_BYPASS_EN
    chk("bypass_rd0", rd_data[31:0], 32'h0000_1234);
`else
    chk("bypass_rd0", rd_data[31:0], 32'h0);
`endif
    chk("bypass_rd1", rd_data[63:32], 32'h0000_0066);
    @(negedge clk);
    wr_valid = 2'b00;
    #1;
    chk("wr3_next", rd_data[31:0], 32'h0000_1234);

    // Debug reads
    dbg_op(1'b0, 16'h1003, 32'h0, cyc);
    chk("dbgrd_lat", 32'(cyc), 32'd2);
    chk("dbgrd_err", {31'h0, dbg_err}, 32'h0);
    chk("dbgrd_data", dbg_rdata, 32'h0000_1234);
    dbg_req = 1'b0;
    @(negedge clk);
    chk("dbgrd_ack1", {31'h0, dbg_ack}, 32'h0);

    dbg_op(1'b0, 16'h0FFF, 32'h0, cyc);
    chk("dbglo_lat", 32'(cyc), 32'd2);
    chk("dbglo_err", {31'h0, dbg_err}, 32'h1);
    chk("dbglo_hold", dbg_rdata, 32'h0000_1234);
    dbg_req = 1'b0;

    dbg_op(1'b0, 16'h1020, 32'h0, cyc);
    chk("dbghi_lat", 32'(cyc), 32'd2);
    chk("dbghi_err", {31'h0, dbg_err}, 32'h1);
    dbg_req = 1'b0;

    dbg_op(1'b0, 16'h1005, 32'h0, cyc);
    chk("dbgrd5_data", dbg_rdata, 32'hBBBB_0002);
    chk("dbgrd5_err", {31'h0, dbg_err}, 32'h0);
    dbg_req = 1'b0;

    // Debug write with free write ports
    dbg_op(1'b1, 16'h1009, 32'h0000_CAFE, cyc);
    chk("dbgwr_lat", 32'(cyc), 32'd2);
    chk("dbgwr_err", {31'h0, dbg_err}, 32'h0);
    dbg_req = 1'b0;
    rd_idx = {5'd9, 5'd9};
    #1;
    chk("dbgwr_rd", rd_data[31:0], 32'h0000_CAFE);

    // Debug write starved by a continuous core write
    @(negedge clk);
    wr_valid = 2'b01; wr_idx = {5'd0, 5'd10}; wr_data = {32'h0, 32'h0000_0010};
    @(negedge clk);
    dbg_req = 1'b1; dbg_wr1_rd0 = 1'b1; dbg_regno = 16'h100B; dbg_wdata = 32'h0000_BEEF;
    repeat (15) @(negedge clk);
    chk("stall_pre", {31'h0, wr_stall}, 32'h0);
    @(negedge clk);
    chk("stall_up", {31'h0, wr_stall}, 32'h1);
    chk("stall_noack", {31'h0, dbg_ack}, 32'h0);
    wr_valid = 2'b00;
    @(negedge clk);
    chk("stall_clr", {31'h0, wr_stall}, 32'h0);
    rd_idx = {5'd10, 5'd11};
    #1;
    chk("starve_wr", rd_data[31:0], 32'h0000_BEEF);
    chk("core_wr10", rd_data[63:32], 32'h0000_0010);
    @(negedge clk);
    chk("starve_ack", {31'h0, dbg_ack}, 32'h1);
    chk("starve_err", {31'h0, dbg_err}, 32'h0);
    dbg_req = 1'b0;
    @(negedge clk);
    chk("starve_ack1", {31'h0, dbg_ack}, 32'h0);

    // Reset while waiting
    wr_valid = 2'b01; wr_idx = {5'd0, 5'd10}; wr_data = {32'h0, 32'h0000_0020};
    @(negedge clk);
    dbg_req = 1'b1; dbg_wr1_rd0 = 1'b1; dbg_regno = 16'h100C; dbg_wdata = 32'h0000_5555;
    repeat (20) @(negedge clk);
    chk("rstwait_stall", {31'h0, wr_stall}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("rstwait_async", {31'h0, wr_stall}, 32'h0);
    wr_valid = 2'b00; dbg_req = 1'b0;
    @(negedge clk) rstn = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (dbg_ack) acks++;
    end
    chk("rstwait_noack", 32'(acks), 32'd0);
    rd_idx = {5'd10, 5'd12};
    #1;
    chk("rstwait_nowr", rd_data[31:0], 32'h0);

    // Held request yields a single ack
    @(negedge clk);
    wr_valid = 2'b01; wr_idx = {5'd0, 5'd3}; wr_data = {32'h0, 32'h0000_0077};
    @(negedge clk);
    wr_valid = 2'b00;
    dbg_op(1'b0, 16'h1003, 32'h0, cyc);
    chk("held_lat", 32'(cyc), 32'd2);
    chk("held_data", dbg_rdata, 32'h0000_0077);
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (dbg_ack) acks++;
    end
    chk("held_single", 32'(acks), 32'd0);
    dbg_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
